// File: rtl/cache_arbiter.sv
// Arbitrates the shared cacheline memory port between the I-cache and D-cache miss paths.
// One requester is served at a time; simultaneous requests alternate.
module cache_arbiter #(
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    typedef enum logic [1:0] {StIdle, StServeI, StServeD, StRelease} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic                  is_write_q;
    logic                  last_grant_d_q;

    logic want_i;
    logic want_d;
    logic grant_i;
    logic grant_d;

    // On a tie, the requester that did not win last time gets the port.
    always_comb begin
        want_i  = i_pmem_read;
        want_d  = d_pmem_read | d_pmem_write;
        grant_d = want_d && (!want_i || !last_grant_d_q);
        grant_i = want_i && !grant_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            addr_q         <= '0;
            wdata_q        <= '0;
            is_write_q     <= 1'b0;
            last_grant_d_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_d) begin
                        state_q        <= StServeD;
                        addr_q         <= d_pmem_address;
                        wdata_q        <= d_pmem_wdata;
                        is_write_q     <= d_pmem_write;
                        last_grant_d_q <= 1'b1;
                    end else if (grant_i) begin
                        state_q        <= StServeI;
                        addr_q         <= i_pmem_address;
                        is_write_q     <= 1'b0;
                        last_grant_d_q <= 1'b0;
                    end
                end
                StServeI, StServeD: begin
                    if (mem_resp) begin
                        state_q <= StRelease;
                    end
                end
                StRelease: state_q <= StIdle;
                default:   state_q <= StIdle;
            endcase
        end
    end

    // Memory-side strobes decode registered state only; resp strobes pass mem_resp through.
    always_comb begin
        mem_read    = (state_q == StServeI) || ((state_q == StServeD) && !is_write_q);
        mem_write   = (state_q == StServeD) && is_write_q;
        mem_address = addr_q;
        mem_wdata   = wdata_q;
        i_pmem_resp = (state_q == StServeI) && mem_resp;
        d_pmem_resp = (state_q == StServeD) && mem_resp;
    end

    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;

endmodule
